// File: rtl/uart_tx_core.sv
// ============================================================================
//  Module      : uart_tx_core
//  Description : UART transmit engine, one frame per start_tx rising edge,
//                5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [7:0] tx_data_i,
    input  logic       start_tx_i,
    input  logic [4:0] cfg_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_core: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             start_q;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [4:0]       cfg_q, cfg_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start_rise;
    logic             bit_end;
    logic [2:0]       last_data_bit;

    // Parity over the configured data width only; bits above N-1 are masked.
    function automatic logic frame_parity(input logic [7:0] data, input logic [4:0] cfg);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - cfg[1:0]);
        return (^(data & mask)) ^ cfg[4];
    endfunction

    assign start_rise    = start_tx_i & ~start_q;
    assign bit_end       = (baud_cnt_q == BAUD_LAST);
    assign last_data_bit = {1'b0, cfg_q[1:0]} + 3'd4;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cfg_q      <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_tx_i;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cfg_q      <= cfg_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cfg_d      = cfg_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    shift_d    = tx_data_i;
                    cfg_d      = cfg_i;
                    parity_d   = frame_parity(tx_data_i, cfg_i);
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == last_data_bit) begin
                        bit_cnt_d = '0;
                        state_d   = cfg_q[3] ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (cfg_q[2] && (bit_cnt_q == 3'd0)) begin
                        bit_cnt_d = 3'd1;
                    end else begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
// ============================================================================
//  Module      : tb_uart_tx_core
//  Description : Self-checking bench for uart_tx_core against a frame model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_core;

    localparam int CPB = 4;
    localparam int BIG = 100000;

    logic       pclk       = 1'b0;
    logic       presetn    = 1'b0;
    logic [7:0] tx_data_i  = 8'h00;
    logic       start_tx_i = 1'b0;
    logic [4:0] cfg_i      = 5'h00;
    logic       tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .tx_data_i  (tx_data_i),
        .start_tx_i (start_tx_i),
        .cfg_i      (cfg_i),
        .tx_o       (tx_o),
        .tx_busy_o  (tx_busy_o),
        .tx_done_o  (tx_done_o)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a frame is a list of bit values; k counts cycles since the accepting edge.
    int          m_k    = BIG;
    int          m_F    = 0;
    logic [11:0] m_bits = '1;
    logic        m_prev = 1'b0;
    logic        m_live = 1'b0;
    logic        m_edge;
    logic        m_par;
    int          m_n, m_p, m_s;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_k    = BIG;
            m_prev = 1'b0;
        end else begin
            m_edge = start_tx_i & ~m_prev;
            m_prev = start_tx_i;
            if ((m_k >= m_F) && m_edge) begin
                m_n    = 5 + int'(cfg_i[1:0]);
                m_p    = int'(cfg_i[3]);
                m_s    = 1 + int'(cfg_i[2]);
                m_bits = '1;
                m_bits[0] = 1'b0;
                m_par  = cfg_i[4];
                for (int i = 0; i < m_n; i++) begin
                    m_bits[1+i] = tx_data_i[i];
                    m_par       = m_par ^ tx_data_i[i];
                end
                if (m_p != 0) m_bits[1+m_n] = m_par;
                m_F = (1 + m_n + m_p + m_s) * CPB;
                m_k = 0;
            end else if (m_k < BIG) begin
                m_k = m_k + 1;
            end
        end
        m_live = 1'b1;
    end

    always @(negedge pclk) begin
        if (m_live) begin
            check("tx_o",      {31'd0, tx_o},      {31'd0, (m_k < m_F) ? m_bits[m_k/CPB] : 1'b1});
            check("tx_busy_o", {31'd0, tx_busy_o}, {31'd0, 1'(m_k < m_F)});
            check("tx_done_o", {31'd0, tx_done_o}, {31'd0, 1'(m_k == m_F)});
        end
    end

    // Drives one frame, sampling tx_o mid-bit and counting done/busy cycles.
    task automatic run_frame(input logic [7:0] d, input logic [4:0] c, input int nb,
                             output logic [11:0] v, output int dones, output int busys);
        v     = '1;
        dones = 0;
        busys = 0;
        @(negedge pclk);
        tx_data_i  = d;
        cfg_i      = c;
        start_tx_i = 1'b1;
        for (int k = 0; k <= nb*CPB + 1; k++) begin
            @(negedge pclk);
            if ((k % CPB == 1) && (k / CPB < nb)) v[k/CPB] = tx_o;
            dones += int'(tx_done_o);
            busys += int'(tx_busy_o);
        end
        start_tx_i = 1'b0;
    endtask

    logic [11:0] v;
    int          dones, busys;

    initial begin
        repeat (3) @(negedge pclk);
        check("reset_tx",   {31'd0, tx_o},      32'd1);
        check("reset_busy", {31'd0, tx_busy_o}, 32'd0);
        check("reset_done", {31'd0, tx_done_o}, 32'd0);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);

        run_frame(8'hA5, 5'h03, 10, v, dones, busys);
        check("8N1_bits",  {20'd0, v}, 32'hF4A);
        check("8N1_done",  dones, 1);
        check("8N1_busy",  busys, 40);

        run_frame(8'h17, 5'h1C, 9, v, dones, busys);
        check("5O2_bits",  {20'd0, v}, 32'hFEE);
        check("5O2_done",  dones, 1);
        check("5O2_busy",  busys, 36);

        run_frame(8'hFF, 5'h0A, 10, v, dones, busys);
        check("7E1_bits",  {20'd0, v}, 32'hFFE);
        check("7E1_done",  dones, 1);
        check("7E1_busy",  busys, 40);

        // Mid-frame start toggles and input changes must not disturb the frame.
        @(negedge pclk);
        tx_data_i = 8'h3C; cfg_i = 5'h03; start_tx_i = 1'b1;
        v = '1; dones = 0;
        for (int k = 0; k < 95; k++) begin
            @(negedge pclk);
            if ((k % CPB == 1) && (k / CPB < 10)) v[k/CPB] = tx_o;
            dones += int'(tx_done_o);
            if (k == 5)  start_tx_i = 1'b0;
            if (k == 7)  start_tx_i = 1'b1;
            if (k == 9)  begin tx_data_i = 8'hFF; cfg_i = 5'h1F; end
            if (k == 15) start_tx_i = 1'b0;
            if (k == 16) start_tx_i = 1'b1;
        end
        check("mid_bits",  {20'd0, v}, 32'hE78);
        check("mid_done",  dones, 1);
        check("mid_idle",  {31'd0, tx_busy_o}, 32'd0);
        start_tx_i = 1'b0;
        @(negedge pclk);

        // Re-trigger inside the done cycle: next frame follows with no gap.
        @(negedge pclk);
        tx_data_i = 8'h55; cfg_i = 5'h03; start_tx_i = 1'b1;
        dones = 0;
        for (int k = 0; k < 95; k++) begin
            @(negedge pclk);
            dones += int'(tx_done_o);
            if (k == 39) start_tx_i = 1'b0;
            if (k == 40) begin
                check("b2b_done_cycle", {31'd0, tx_done_o}, 32'd1);
                start_tx_i = 1'b1;
            end
            if (k == 41) begin
                check("b2b_start_tx",   {31'd0, tx_o},      32'd0);
                check("b2b_start_busy", {31'd0, tx_busy_o}, 32'd1);
            end
        end
        check("b2b_done", dones, 2);
        start_tx_i = 1'b0;
        @(negedge pclk);

        // Asynchronous reset in the middle of the data bits.
        @(negedge pclk);
        tx_data_i = 8'hA5; cfg_i = 5'h03; start_tx_i = 1'b1;
        repeat (14) @(negedge pclk);
        check("pre_rst_busy", {31'd0, tx_busy_o}, 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("rst_tx",   {31'd0, tx_o},      32'd1);
        check("rst_busy", {31'd0, tx_busy_o}, 32'd0);
        check("rst_done", {31'd0, tx_done_o}, 32'd0);
        @(negedge pclk);
        start_tx_i = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge pclk);
            dones += int'(tx_done_o);
        end
        check("post_rst_done", dones, 0);
        check("post_rst_tx",   {31'd0, tx_o}, 32'd1);

        // Random traffic: inputs change every cycle, start toggles sporadically.
        for (int c = 0; c < 4000; c++) begin
            @(negedge pclk);
            tx_data_i = 8'($urandom);
            cfg_i     = 5'($urandom);
            if ($urandom_range(0, 15) == 0) start_tx_i = ~start_tx_i;
            if ($urandom_range(0, 999) == 0) begin
                #2 presetn = 1'b0;
                @(negedge pclk);
                presetn = 1'b1;
            end
        end

        repeat (2) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART transmit engine that sits directly downstream of the APB register block. It consumes the TX data byte, the start_tx control level and the 5-bit config word, and serialises one frame per start request onto tx_o. It returns a one-cycle tx_done pulse, which feeds the register block's sticky TX-done status bit. Baud timing comes from an internal clock divider clocked by pclk.

Parameters:
CLKS_PER_BIT, 868, pclk cycles per serial bit (100 MHz / 115200); legal range >= 2; counter width $clog2(CLKS_PER_BIT).

Ports:
pclk  input  1  APB/system clock; all logic on rising edge
presetn  input  1  reset, asynchronous, active-low
tx_data_i  input  8  byte to send (tx_data_reg[7:0]); sampled at frame start
start_tx_i  input  1  start level (ctrl_reg[0]); rising edge requests a frame
cfg_i  input  5  [1:0] data bits (00=5, 01=6, 10=7, 11=8); [2] stop bits (0=1, 1=2); [3] parity enable; [4] parity type (0=even, 1=odd)
tx_o  output  1  serial line, idle high
tx_busy_o  output  1  high while a frame is in progress (state != IDLE)
tx_done_o  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: tx_o=1, tx_busy_o=0, tx_done_o=0, state=IDLE, start_q=0, all counters and shadow registers 0. All outputs are registered.
- Edge detect: start_q <= start_tx_i every cycle; start_rise = start_tx_i & ~start_q. Because start_q resets to 0, start_tx_i held high at reset release counts as one edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_o=1.
  - On start_rise, latch tx_data_i into shift_reg and cfg_i into cfg_shadow.
  - Clear bit_cnt and baud_cnt; go to START.
- Every non-IDLE state holds its bit for exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1; the state advances when baud_cnt == CLKS_PER_BIT-1.
- START: tx_o=0.
- DATA:
  - tx_o=shift_reg[0], LSB first; shift right at each bit end.
  - N = 5 + cfg_shadow[1:0]. After bit N-1, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - tx_o = (XOR of the N data bits of the latched byte) XOR cfg_shadow[4].
  - Bits above N-1 are excluded from the XOR.
- STOP: tx_o=1 for 1 or 2 bit times, per cfg_shadow[2]; then go to IDLE.
- Latency: if the start edge is sampled at clock edge E0, tx_o goes low after E0.
- Frame length: F = (1 + N + P + S) * CLKS_PER_BIT cycles, where P = parity enabled (0/1) and S = stop bits (1/2).
- Frame completion: at E0+F the FSM enters IDLE and tx_done_o is high for exactly the one cycle following E0+F. tx_busy_o falls in that same cycle.
- Boundary conditions:
  - Rising edge while busy is ignored and not queued; start_tx_i must fall and rise again.
  - Rising edge in the tx_done cycle (FSM already IDLE) is accepted; the next frame starts back-to-back with no extra idle bit.
  - Changes to tx_data_i or cfg_i mid-frame have no effect on the current frame (shadow copies are used).
  - start_tx_i held high after a frame does not retrigger.
  - Reset mid-frame: immediate return to reset values; tx_o=1 asynchronously; no tx_done pulse.

Test Plan:
- CLKS_PER_BIT=4, cfg=0x03 (8N1), tx_data=0xA5, raise start -> tx_o per 4 cycles: 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles; tx_done 1 cycle after E0+40.
- cfg=0x1C (5 bits, odd parity, 2 stop), tx_data=0x17 -> 0,1,1,1,0,1,P=1,1,1 (36 cycles); done pulse once.
- cfg=0x0A (7 bits, even parity, 1 stop), tx_data=0xFF -> 7 ones, P=1 (bit7 excluded), stop; 40 cycles total.
- Toggle start_tx low/high mid-frame, and change tx_data and cfg mid-frame -> frame unchanged, no second frame, exactly one done pulse.
- Hold start_tx high through done, then toggle low/high in the done cycle -> exactly one extra frame, starting in the same cycle as done ends, no idle gap.
- Assert presetn low mid-DATA -> tx_o=1, busy=0 immediately, no done; after release with start_tx low, line stays idle.
